// File: rtl/pc_unit_pkg.sv
// Shared constants and types for the registered program-counter unit.
package pc_unit_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        EXC_INST_MISALIGNED = 2'd0
    } exc_cause_t;

endpackage

// File: rtl/pc_unit_branch_cmp.sv
// Branch condition evaluator: decides taken/not-taken from funct3 and the
// two operands. Reserved funct3 codes (010, 011) are never taken.
module branch_cmp
    import pc_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   fun3,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
    output logic         taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    // Select the condition named by funct3
    always_comb begin
        taken = 1'b0;
        case (fun3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Registered program-counter unit: owns the fetch PC, resolves branches,
// JAL and JALR from execute, redirects fetch and raises a trap on a
// misaligned jump target. Optional branch counters are built when
// PC_UNIT_PERF_EN is defined.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int          MODE      = 32,
    parameter logic [63:0] RESET_VEC = 64'h0,
    parameter logic [63:0] TRAP_VEC  = 64'h100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [MODE-1:0] ex_pc,
    input  logic [6:0]      opcode,
    input  logic [2:0]      fun3,
    input  logic [MODE-1:0] rs1,
    input  logic [MODE-1:0] rs2,
    input  logic [31:0]     imm,
    input  logic            stall,
    output logic [MODE-1:0] pc,
    output logic            pc_valid,
    input  logic            fetch_ready,
    output logic            redirect,
    output logic            exc_valid,
    output logic [1:0]      exc_cause,
    output logic [MODE-1:0] exc_tval,
    input  logic            exc_ack
`ifdef PC_UNIT_PERF_EN
    ,
    output logic [31:0]     br_total,
    output logic [31:0]     br_taken
`endif
);

    localparam logic [MODE-1:0] RESET_PC = RESET_VEC[MODE-1:0];
    localparam logic [MODE-1:0] TRAP_PC  = TRAP_VEC[MODE-1:0];

    pc_state_t       state_reg, state_next;
    logic [MODE-1:0] pc_reg, pc_next;
    logic            exc_valid_reg, exc_valid_next;
    exc_cause_t      exc_cause_reg, exc_cause_next;
    logic [MODE-1:0] exc_tval_reg, exc_tval_next;

    logic [MODE-1:0] imm_ext;
    logic            cmp_taken;
    logic            xfer_taken;
    logic [MODE-1:0] target;
    logic            resolve;

    // Sign-extension is a no-op at MODE=32 and widens for MODE=64
    assign imm_ext = MODE'($signed(imm));

    branch_cmp #(.W(MODE)) u_branch_cmp (
        .fun3  (fun3),
        .rs1   (rs1),
        .rs2   (rs2),
        .taken (cmp_taken)
    );

    // A resolution only counts in RUN and when the pipeline is moving
    assign resolve = ex_valid && !stall && (state_reg == RUN);

    // Decode the transfer kind and compute its target
    always_comb begin
        xfer_taken = 1'b0;
        target     = ex_pc + imm_ext;
        case (opcode)
            OP_BRANCH: xfer_taken = cmp_taken;
            OP_JAL:    xfer_taken = 1'b1;
            OP_JALR: begin
                xfer_taken = 1'b1;
                target     = (rs1 + imm_ext) & ~MODE'(1);
            end
            default:   xfer_taken = 1'b0;
        endcase
    end

    // State and datapath registers; stall is handled by the next-state logic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_PC;
            exc_valid_reg <= 1'b0;
            exc_cause_reg <= EXC_INST_MISALIGNED;
            exc_tval_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            exc_valid_reg <= exc_valid_next;
            exc_cause_reg <= exc_cause_next;
            exc_tval_reg  <= exc_tval_next;
        end
    end

    // Next-state, next-PC, trap capture and handshake outputs
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        exc_valid_next = exc_valid_reg;
        exc_cause_next = exc_cause_reg;
        exc_tval_next  = exc_tval_reg;
        pc_valid       = 1'b0;
        redirect       = 1'b0;
        case (state_reg)
            BOOT: begin
                if (!stall) state_next = RUN;
            end
            RUN: begin
                pc_valid = !stall;
                if (resolve && xfer_taken) begin
                    redirect = 1'b1;
                    if (target[1:0] == 2'b00) begin
                        pc_next = target;
                    end else begin
                        pc_next        = TRAP_PC;
                        exc_valid_next = 1'b1;
                        exc_cause_next = EXC_INST_MISALIGNED;
                        exc_tval_next  = target;
                        state_next     = TRAP;
                    end
                end else if (fetch_ready && !stall) begin
                    pc_next = pc_reg + MODE'(4);
                end
            end
            TRAP: begin
                if (!stall && exc_valid_reg && exc_ack) begin
                    exc_valid_next = 1'b0;
                    state_next     = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    assign pc        = pc_reg;
    assign exc_valid = exc_valid_reg;
    assign exc_cause = exc_cause_reg;
    assign exc_tval  = exc_tval_reg;

`ifdef PC_UNIT_PERF_EN
    logic [31:0] br_total_reg;
    logic [31:0] br_taken_reg;
    logic        br_count;

    assign br_count = resolve && (opcode == OP_BRANCH);

    // Saturating counters of resolved and taken conditional branches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_total_reg <= '0;
            br_taken_reg <= '0;
        end else if (br_count) begin
            if (br_total_reg != '1) br_total_reg <= br_total_reg + 32'd1;
            if (cmp_taken && br_taken_reg != '1) br_taken_reg <= br_taken_reg + 32'd1;
        end
    end

    assign br_total = br_total_reg;
    assign br_taken = br_taken_reg;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit with hand-computed expectations.
// Define PC_UNIT_PERF_EN to also exercise the branch counters.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [6:0]  opcode;
    logic [2:0]  fun3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        stall;
    logic [31:0] pc;
    logic        pc_valid;
    logic        fetch_ready;
    logic        redirect;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_tval;
    logic        exc_ack;
`ifdef PC_UNIT_PERF_EN
    logic [31:0] br_total;
    logic [31:0] br_taken;
`endif

    int checks = 0;
    int errors = 0;

    pc_unit #(.MODE(32), .RESET_VEC(64'h0), .TRAP_VEC(64'h100)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .opcode      (opcode),
        .fun3        (fun3),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .stall       (stall),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .fetch_ready (fetch_ready),
        .redirect    (redirect),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .exc_tval    (exc_tval),
        .exc_ack     (exc_ack)
`ifdef PC_UNIT_PERF_EN
        ,
        .br_total    (br_total),
        .br_taken    (br_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] epc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im);
        ex_valid = v;
        opcode   = op;
        fun3     = f3;
        ex_pc    = epc;
        rs1      = a;
        rs2      = b;
        imm      = im;
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; exc_ack = 1'b0; fetch_ready = 1'b1;
        drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_pc_valid", pc_valid, 1'b0);
        check("rst_exc_valid", exc_valid, 1'b0);
        check("rst_exc_tval", exc_tval, 32'h0);
        check("rst_redirect", redirect, 1'b0);

        // Boot then sequential fetch
        reset = 1'b0; #1;
        check("boot_pc_valid", pc_valid, 1'b0);
        tick();
        check("run_pc0", pc, 32'h0);
        check("run_pc_valid", pc_valid, 1'b1);
        tick();
        check("run_pc4", pc, 32'h4);
        tick();
        check("run_pc8", pc, 32'h8);

        // BLT signed taken
        drive(1'b1, 7'b1100011, 3'b100, 32'h40, 32'hFFFFFFFF, 32'h1, 32'h10);
        check("blt_redirect", redirect, 1'b1);
        tick();
        check("blt_pc", pc, 32'h50);
        // Same operands, BLTU: not taken
        drive(1'b1, 7'b1100011, 3'b110, 32'h40, 32'hFFFFFFFF, 32'h1, 32'h10);
        check("bltu_redirect", redirect, 1'b0);
        tick();
        check("bltu_pc", pc, 32'h54);
        // Reserved funct3 never taken, even with equal operands
        drive(1'b1, 7'b1100011, 3'b010, 32'h40, 32'h7, 32'h7, 32'h10);
        check("f3_010_redirect", redirect, 1'b0);
        tick();
        check("f3_010_pc", pc, 32'h58);

        // JALR clears bit 0, target aligned
        drive(1'b1, 7'b1100111, 3'b000, 32'h80, 32'h201, 32'h0, 32'h0);
        check("jalr_redirect", redirect, 1'b1);
        tick();
        check("jalr_pc", pc, 32'h200);
        check("jalr_no_exc", exc_valid, 1'b0);

        // Misaligned JAL
        drive(1'b1, 7'b1101111, 3'b000, 32'h20, 32'h0, 32'h0, 32'h6);
        check("mjal_redirect", redirect, 1'b1);
        tick();
        check("mjal_exc_valid", exc_valid, 1'b1);
        check("mjal_exc_tval", exc_tval, 32'h26);
        check("mjal_exc_cause", exc_cause, 2'd0);
        check("mjal_pc", pc, 32'h100);
        check("trap_pc_valid", pc_valid, 1'b0);
        // ex_valid ignored in TRAP
        drive(1'b1, 7'b1101111, 3'b000, 32'h0, 32'h0, 32'h0, 32'h400);
        check("trap_ignore_redirect", redirect, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("trap_hold_exc", exc_valid, 1'b1);
            check("trap_hold_pc", pc, 32'h100);
        end
        drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        check("ack_exc_valid", exc_valid, 1'b0);
        check("ack_pc_valid", pc_valid, 1'b1);
        check("ack_pc", pc, 32'h100);
        tick();
        check("after_trap_pc", pc, 32'h104);

        // Stall during taken BEQ
        stall = 1'b1;
        drive(1'b1, 7'b1100011, 3'b000, 32'h300, 32'h5, 32'h5, 32'h20);
        check("stall_redirect", redirect, 1'b0);
        check("stall_pc_valid", pc_valid, 1'b0);
        tick();
        check("stall_pc", pc, 32'h104);
        stall = 1'b0; #1;
        check("unstall_redirect", redirect, 1'b1);
        tick();
        check("unstall_pc", pc, 32'h320);

        // Wrap at top of address space
        drive(1'b1, 7'b1101111, 3'b000, 32'hFFFFFFF0, 32'h0, 32'h0, 32'hC);
        tick();
        check("wrap_pre_pc", pc, 32'hFFFFFFFC);
        drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("wrap_pc", pc, 32'h0);

        // Reset while in TRAP: JALR to 0x102 is misaligned
        drive(1'b1, 7'b1100111, 3'b000, 32'h0, 32'h102, 32'h0, 32'h0);
        tick();
        check("trap2_exc_valid", exc_valid, 1'b1);
        check("trap2_exc_tval", exc_tval, 32'h102);
        drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1; #1;
        check("trap_rst_exc_valid", exc_valid, 1'b0);
        check("trap_rst_pc", pc, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("rerun_pc_valid", pc_valid, 1'b1);

`ifdef PC_UNIT_PERF_EN
        check("perf_total_rst", br_total, 32'd0);
        // BEQ taken, BNE not taken, BGEU taken, plus a JAL and a stalled BEQ
        drive(1'b1, 7'b1100011, 3'b000, 32'h0, 32'h3, 32'h3, 32'h40);
        tick();
        drive(1'b1, 7'b1100011, 3'b001, 32'h0, 32'h3, 32'h3, 32'h40);
        tick();
        drive(1'b1, 7'b1100011, 3'b111, 32'h0, 32'h9, 32'h3, 32'h80);
        tick();
        drive(1'b1, 7'b1101111, 3'b000, 32'h0, 32'h0, 32'h0, 32'h100);
        tick();
        stall = 1'b1;
        drive(1'b1, 7'b1100011, 3'b000, 32'h0, 32'h3, 32'h3, 32'h40);
        tick();
        stall = 1'b0;
        drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("perf_total", br_total, 32'd3);
        check("perf_taken", br_taken, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Registered program-counter unit for the RV32I core. It is the sequential successor to the combinational next-PC logic. It owns the fetch PC and issues it to instruction fetch with a valid/ready handshake. It resolves branches, JAL and JALR that arrive from execute, and redirects fetch when a transfer is taken. A misaligned jump target raises a trap through an acknowledge handshake.

## Interface
Parameters:
- MODE, 32: address/data width (32 or 64).
- RESET_VEC, 0: fetch PC after reset.
- TRAP_VEC, 'h100: fetch PC after a misaligned-target trap.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high.
- ex_valid  in  1  a resolving instruction is present on the ex_* inputs.
- ex_pc  in  MODE  PC of that instruction.
- opcode  in  7  opcode of that instruction.
- fun3  in  3  funct3 of that instruction.
- rs1  in  MODE  source operand 1.
- rs2  in  MODE  source operand 2.
- imm  in  32  immediate; sign-extended (MODE=64) or truncated to MODE.
- stall  in  1  pipeline freeze; while high, nothing updates and no outputs are asserted.
- pc  out  MODE  fetch address.
- pc_valid  out  1  pc is valid for fetch.
- fetch_ready  in  1  fetch accepts pc this cycle.
- redirect  out  1  flush younger instructions; pc changes next cycle.
- exc_valid  out  1  trap pending.
- exc_cause  out  2  0 = instruction-address-misaligned; other codes reserved.
- exc_tval  out  MODE  offending target address.
- exc_ack  in  1  trap accepted.

## Operation
- States: BOOT, RUN, TRAP.
- Reset state: BOOT, pc=RESET_VEC, pc_valid=0, redirect=0, exc_valid=0, exc_cause=0, exc_tval=0.
- BOOT: after one cycle, go to RUN.
- RUN, sequential fetch:
  - pc_valid=1.
  - If fetch_ready && !stall, then pc <= pc+4.
  - Addition is modulo 2^MODE, with no overflow flag.
- Resolution (RUN only) happens when ex_valid && !stall.
- Branch (1100011) conditions:
  - BEQ: rs1 == rs2.
  - BNE: rs1 != rs2.
  - BLT: rs1 < rs2, signed.
  - BGE: rs1 >= rs2, signed.
  - BLTU: rs1 < rs2, unsigned.
  - BGEU: rs1 >= rs2, unsigned.
  - fun3 010 and 011 are never taken.
- Branch target: ex_pc+imm.
- JAL (1101111): always taken; target is ex_pc+imm.
- JALR (1100111): always taken; target is (rs1+imm) with bit 0 cleared.
- Any other opcode produces no action.
- Taken transfer with aligned target (target[1:0]==0):
  - redirect=1.
  - pc <= target.
  - The target has priority over pc+4.
- Taken transfer with misaligned target (target[1:0]!=0):
  - redirect=1.
  - exc_cause <= 0, exc_tval <= target, exc_valid <= 1.
  - pc <= TRAP_VEC.
  - Go to TRAP.
- A not-taken branch is never checked for alignment.
- TRAP:
  - pc_valid=0 and ex_valid is ignored.
  - exc_valid holds until exc_ack is sampled high.
  - Then exc_valid <= 0 and go to RUN, fetching from TRAP_VEC.
- stall high: all registers hold and redirect=0. Fetch and execute hold their own state.
- Reset asserted in any state returns to the reset values on the next evaluation, asynchronously; a pending trap is discarded.

## Timing
- redirect is combinational from the ex_* inputs in the resolving cycle.
- The new pc is visible on the following edge; latency from resolution to the target on pc is 1 cycle.
- exc_valid, exc_cause and exc_tval are registered; they appear 1 cycle after the misaligned resolution.
- exc_ack is sampled only while exc_valid=1. If exc_ack is high in the first cycle exc_valid is high, TRAP lasts exactly 1 cycle.
- A pc handshake completes on a cycle where pc_valid && fetch_ready && !stall.
- At most one resolution per cycle.

## Configuration
- Macro: PC_UNIT_PERF_EN.
- Defined:
  - Adds output ports br_total (32) and br_taken (32).
  - br_total counts every resolved branch-opcode instruction; br_taken counts the taken ones. JAL and JALR are excluded.
  - Both counters saturate at all-ones, reset to 0, and do not count while stall or TRAP is active.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- pc_unit_pkg holds:
  - Opcode constants: OP_BRANCH, OP_JAL, OP_JALR.
  - fun3 constants for BEQ through BGEU.
  - State enum pc_state_t: BOOT, RUN, TRAP.
  - Exception-cause enum exc_cause_t.
- Sub-module branch_cmp, combinational: fun3, rs1, rs2 -> taken. It encapsulates the signed/unsigned comparisons.

## Test plan
- Boot and sequential fetch: release reset, fetch_ready=1 -> pc_valid=0 for 1 cycle, then pc = 0, 4, 8 on successive cycles.
- BLT signed: rs1=0xFFFFFFFF, rs2=1, ex_pc=0x40, imm=0x10 -> redirect=1, next pc=0x50. The same operands with BLTU -> not taken, no redirect.
- JALR bit 0: rs1=0x201, imm=0 -> next pc=0x200, no exception.
- Misaligned JAL: ex_pc=0x20, imm=0x6 -> redirect=1. exc_valid=1 next cycle with exc_tval=0x26 and pc=TRAP_VEC. Hold exc_ack=0 for 3 cycles, then 1 -> state RUN, pc_valid=1 at TRAP_VEC.
- Stall: stall=1 during a taken BEQ -> pc is unchanged and redirect=0. Deassert stall -> the redirect happens.
- Wrap and reset: pc=0xFFFFFFFC with fetch_ready=1 -> pc=0. Assert reset in TRAP -> exc_valid=0 immediately and pc=RESET_VEC. With PC_UNIT_PERF_EN defined, 3 branches with 2 taken -> br_total=3, br_taken=2.
